ce_divider_bank: RTL
====================

CE_DIVIDER_BANK -- requirements
Module: ce_divider_bank

Interface
REQ-001 SHALL have parameter CH, default 4: number of independent clock-enable channels (1..16).
REQ-002 SHALL have parameter DW, default 6: divider field width per channel.
REQ-003 SHALL have parameter DIV_RST, default 23: divider value loaded into every channel at reset.
REQ-004 SHALL have port clk_sys, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port en, input, CH: per-channel run enable.
REQ-007 SHALL have port restart, input, CH: per-channel synchronous counter restart strobe.
REQ-008 SHALL have port hold, input, CH: per-channel divider-reload inhibit, for example while a bus cycle is in flight.
REQ-009 SHALL have port div_in, input, CH*DW: requested divider (period-1) per channel; channel i occupies bits [i*DW +: DW].
REQ-010 SHALL have port ce_p, output, CH: positive-phase enable pulse per channel.
REQ-011 SHALL have port ce_n, output, CH: mid-period (negative-phase) enable pulse per channel.
REQ-012 SHALL have port div_cur, output, CH*DW: divider currently in effect per channel.

Function
REQ-013 Each channel SHALL hold a DW-bit counter cnt and an active divider d (driven on div_cur).
REQ-014 With en=1, cnt SHALL advance 0,1,..,d,0 once per clk_sys; the period SHALL be d+1 cycles.
REQ-015 d SHALL load from div_in only in the wrap cycle (cnt==d) and only when hold=0; otherwise d SHALL keep its value.
REQ-016 A change in div_in mid-period SHALL never shorten or lengthen the current period.
REQ-017 ce_p SHALL be registered and high exactly in cycles where cnt==0.
REQ-018 ce_n SHALL be registered and high exactly in cycles where cnt==(d+1)>>1, computed at DW+1 bits, and d!=0.
REQ-019 If d==0, ce_p SHALL be constantly high while en=1, and ce_n SHALL be constantly low.
REQ-020 If en=0, cnt SHALL freeze, ce_p and ce_n SHALL be low, and d SHALL not reload.
REQ-021 restart=1 with en=1 SHALL set cnt to 0 on the next edge, so ce_p is high in the following cycle.
REQ-022 If restart coincides with a wrap, restart SHALL take precedence for cnt; the d reload SHALL still occur if hold=0.
REQ-023 If restart coincides with en=0, restart SHALL be ignored.
REQ-024 Channels SHALL be fully independent; no channel's inputs SHALL affect another channel's outputs.

Reset
REQ-025 While reset=1: cnt=0, d=DIV_RST[DW-1:0], ce_p=0, ce_n=0, div_cur=DIV_RST per channel.
REQ-026 After reset release with en=1, the first ce_p SHALL occur d+1 cycles after the first active edge.
REQ-027 Reset asserted mid-period SHALL abort the period immediately, with no glitch pulse on ce_p or ce_n.

Configuration
REQ-028 Macro CE_NEG_PHASE_EN SHALL control the ce_n logic.
- Defined: ce_n behaves per REQ-018 and REQ-019.
- Undefined: ce_n is tied to 0 and its compare logic is omitted.
- ce_p and div_cur are identical in both builds.

Structure
REQ-029 Shared package ce_pkg SHALL hold:
- default constants CE_CH_DEF=4, CE_DW_DEF=6, CE_DIV_RST_DEF=23;
- typedef ce_div_t (logic [CE_DW_DEF-1:0]).
REQ-030 Per-channel logic SHALL live in one sub-module, ce_channel, instantiated CH times by a generate loop; the top contains only slicing.

Verification
REQ-031 Reset release, DIV_RST=23, en=1 -> ce_p pulses every 24 cycles; ce_n pulses at cnt==12.
REQ-032 div_in changes 23->11 at cnt==5 with hold=0 -> current period stays 24 cycles; next periods are 12 cycles; ce_n at cnt==6.
REQ-033 hold=1 across a wrap with div_in=11, d=23 -> d stays 23; reload occurs at the first wrap with hold=0.
REQ-034 d=0 -> ce_p constant 1, ce_n 0; d=1 -> ce_p and ce_n alternate every cycle.
REQ-035 restart at cnt==d, and separately at cnt==7 -> ce_p the next cycle in both cases; with en=0, no pulses and cnt frozen.
REQ-036 Build without CE_NEG_PHASE_EN, CH=3 channels with d=2, 5, 9 -> ce_n is always 0; ce_p periods are 3, 6, 10 with no cross-channel interference.

Source files
------------

// File: rtl/ce_pkg.sv
// ce_pkg: shared defaults and divider type for the clock-enable divider bank
package ce_pkg;
   localparam int CE_CH_DEF      = 4;
   localparam int CE_DW_DEF      = 6;
   localparam int CE_DIV_RST_DEF = 23;
   typedef logic [CE_DW_DEF-1:0] ce_div_t;
endpackage

// File: rtl/ce_channel.sv
// ce_channel: one clock-enable divider channel; ce_n logic present only with CE_NEG_PHASE_EN
module ce_channel
   import ce_pkg::*;
#(
   parameter int DW      = CE_DW_DEF,
   parameter int DIV_RST = CE_DIV_RST_DEF
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          en,
   input  logic          restart,
   input  logic          hold,
   input  logic [DW-1:0] div_in,
   output logic          ce_p,
   output logic          ce_n,
   output logic [DW-1:0] div_cur
);
   logic [DW-1:0] cnt, d, cnt_nx, d_nx;
   logic          wrap;
   assign wrap    = cnt == d;
   assign cnt_nx  = (restart || wrap) ? '0 : cnt + DW'(1);
   assign d_nx    = (wrap && !hold) ? div_in : d;
   assign div_cur = d;
   // counter and divider advance only while enabled; ce_p flags the cycle the counter sits at 0
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         cnt  <= '0;
         d    <= DW'(DIV_RST);
         ce_p <= 1'b0;
      end else begin
         ce_p <= en && cnt_nx == '0;
         if (en) begin
            cnt <= cnt_nx;
            d   <= d_nx;
         end
      end
`ifdef CE_NEG_PHASE_EN
   logic [DW:0] half;
   assign half = ({1'b0, d_nx} + (DW+1)'(1)) >> 1;
   // mid-period pulse compared against the divider that is in effect next cycle
   always_ff @(posedge clk_sys or posedge reset)
      if (reset) ce_n <= 1'b0;
      else       ce_n <= en && d_nx != '0 && {1'b0, cnt_nx} == half;
`else
   assign ce_n = 1'b0;
`endif
endmodule

// File: rtl/ce_divider_bank.sv
// ce_divider_bank: CH independent clock-enable dividers; ce_n enabled by CE_NEG_PHASE_EN
module ce_divider_bank
   import ce_pkg::*;
#(
   parameter int CH      = CE_CH_DEF,
   parameter int DW      = CE_DW_DEF,
   parameter int DIV_RST = CE_DIV_RST_DEF
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [CH-1:0]    en,
   input  logic [CH-1:0]    restart,
   input  logic [CH-1:0]    hold,
   input  logic [CH*DW-1:0] div_in,
   output logic [CH-1:0]    ce_p,
   output logic [CH-1:0]    ce_n,
   output logic [CH*DW-1:0] div_cur
);
   for (genvar i = 0; i < CH; i++) begin : g_ch
      ce_channel #(.DW(DW), .DIV_RST(DIV_RST)) u_ch (
         .clk_sys (clk_sys),
         .reset   (reset),
         .en      (en[i]),
         .restart (restart[i]),
         .hold    (hold[i]),
         .div_in  (div_in[i*DW +: DW]),
         .ce_p    (ce_p[i]),
         .ce_n    (ce_n[i]),
         .div_cur (div_cur[i*DW +: DW])
      );
   end
endmodule
